// File: rtl/pipeline_run_controller_pkg.sv
// Shared command and state encodings for the pipeline run controller.
// Also holds a helper that says which states let the core pipeline advance.
package pipeline_run_controller_pkg;

  typedef enum logic [1:0] {
    CMD_RESET_CORE = 2'b00,
    CMD_RUN        = 2'b01,
    CMD_STEP       = 2'b10,
    CMD_HALT       = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  // States in which the core pipeline is allowed to advance.
  function automatic logic is_active(input state_t s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/pipeline_run_controller_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// The clear input takes precedence over an increment in the same cycle.
module pipeline_run_controller_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_run_controller.sv
// Run/step/halt sequencer for the 5-stage core: drives the core stall and reset pulse,
// auto-halts on HALT_WORD after draining the pipeline, and counts unstalled cycles.
module pipeline_run_controller
  import pipeline_run_controller_pkg::*;
#(
  parameter int              SIZE         = 32,
  parameter logic [SIZE-1:0] HALT_WORD    = {SIZE{1'b1}},
  parameter int              DRAIN_CYCLES = 4,
  parameter int              COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  output logic               o_cmd_ready,
  input  logic [SIZE-1:0]    i_instruction,
  output logic               o_stall,
  output logic               o_core_rst,
  output logic               o_running,
  output logic               o_halted,
  output logic               o_done,
  output logic [COUNT_W-1:0] o_cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  // Counter runs DRAIN_CYCLES-1 down to 0, giving exactly DRAIN_CYCLES drain cycles.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t             state, state_next;
  logic [DRAIN_W-1:0] drain_cnt, drain_next;
  logic               done_next, core_rst_next, cnt_clr;
  logic               cmd_acc, halt_seen;
  cmd_t               cmd;

  assign cmd       = cmd_t'(i_cmd);
  assign cmd_acc   = i_cmd_valid && o_cmd_ready;
  assign halt_seen = (i_instruction == HALT_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      o_done     <= 1'b0;
      o_core_rst <= 1'b0;
    end else begin
      state      <= state_next;
      drain_cnt  <= drain_next;
      o_done     <= done_next;
      o_core_rst <= core_rst_next;
    end
  end

  always_comb begin
    state_next    = state;
    drain_next    = drain_cnt;
    done_next     = 1'b0;
    core_rst_next = 1'b0;
    cnt_clr       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_acc) begin
          case (cmd)
            CMD_RUN:        state_next = ST_RUN;
            CMD_STEP:       state_next = ST_STEP;
            CMD_RESET_CORE: begin
              core_rst_next = 1'b1;
              cnt_clr       = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // A fetched HALT_WORD outranks a host HALT in the same cycle.
        if (halt_seen) begin
          state_next = ST_DRAIN;
          drain_next = DRAIN_LOAD;
        end else if (cmd_acc && (cmd == CMD_HALT)) begin
          state_next = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_seen) begin
          state_next = ST_DRAIN;
          drain_next = DRAIN_LOAD;
        end else begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) begin
          state_next = ST_HALTED;
          done_next  = 1'b1;
        end else begin
          drain_next = drain_cnt - DRAIN_W'(1);
        end
      end
      ST_HALTED: begin
        if (cmd_acc && (cmd == CMD_RESET_CORE)) begin
          state_next    = ST_IDLE;
          core_rst_next = 1'b1;
          cnt_clr       = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_running   = is_active(state);
  assign o_stall     = !is_active(state);
  assign o_halted    = (state == ST_HALTED);
  assign o_cmd_ready = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_HALTED);

  pipeline_run_controller_sat_counter #(
    .W (COUNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (!o_stall),
    .clr   (cnt_clr),
    .count (o_cycle_count)
  );

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Bench for pipeline_run_controller: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model, on a 32-bit and a 4-bit counter build.
module tb_pipeline_run_controller;

  localparam logic [1:0]  C_RESET = 2'b00;
  localparam logic [1:0]  C_RUN   = 2'b01;
  localparam logic [1:0]  C_STEP  = 2'b10;
  localparam logic [1:0]  C_HALT  = 2'b11;
  localparam logic [31:0] HALT_W  = 32'hFFFF_FFFF;
  localparam int          DRAIN_N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic [1:0]  i_cmd = 2'b00;
  logic [31:0] i_instruction = 32'h0;

  logic        ready_a, stall_a, core_rst_a, running_a, halted_a, done_a;
  logic [31:0] cnt_a;
  logic        ready_b, stall_b, core_rst_b, running_b, halted_b, done_b;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  pipeline_run_controller dut (
    .clk (clk), .rst (rst), .i_cmd_valid (i_cmd_valid), .i_cmd (i_cmd),
    .o_cmd_ready (ready_a), .i_instruction (i_instruction), .o_stall (stall_a),
    .o_core_rst (core_rst_a), .o_running (running_a), .o_halted (halted_a),
    .o_done (done_a), .o_cycle_count (cnt_a)
  );

  pipeline_run_controller #(.COUNT_W (4)) dut_s (
    .clk (clk), .rst (rst), .i_cmd_valid (i_cmd_valid), .i_cmd (i_cmd),
    .o_cmd_ready (ready_b), .i_instruction (i_instruction), .o_stall (stall_b),
    .o_core_rst (core_rst_b), .o_running (running_b), .o_halted (halted_b),
    .o_done (done_b), .o_cycle_count (cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: operating mode, drain cycles remaining, unbounded cycle count.
  typedef enum int {M_IDLE, M_RUN, M_STEP, M_DRAIN, M_HALTED} mode_t;
  mode_t   m_mode = M_IDLE;
  int      m_drain_left = 0;
  bit      m_done = 1'b0;
  bit      m_core_rst = 1'b0;
  longint  m_count = 0;

  function automatic bit m_active();
    return (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
  endfunction

  function automatic bit m_ready();
    return (m_mode == M_IDLE) || (m_mode == M_RUN) || (m_mode == M_HALTED);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_drain_left = 0; m_done = 1'b0; m_core_rst = 1'b0; m_count = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] c, input logic [31:0] instr);
    bit acc;
    acc = v && m_ready();
    m_done = 1'b0;
    m_core_rst = 1'b0;
    if (m_active()) m_count++;
    case (m_mode)
      M_IDLE: if (acc) begin
        if (c == C_RUN) m_mode = M_RUN;
        else if (c == C_STEP) m_mode = M_STEP;
        else if (c == C_RESET) begin m_core_rst = 1'b1; m_count = 0; end
      end
      M_RUN: begin
        if (instr == HALT_W) begin m_mode = M_DRAIN; m_drain_left = DRAIN_N; end
        else if (acc && c == C_HALT) m_mode = M_IDLE;
      end
      M_STEP: begin
        if (instr == HALT_W) begin m_mode = M_DRAIN; m_drain_left = DRAIN_N; end
        else begin m_mode = M_IDLE; m_done = 1'b1; end
      end
      M_DRAIN: begin
        m_drain_left--;
        if (m_drain_left == 0) begin m_mode = M_HALTED; m_done = 1'b1; end
      end
      M_HALTED: if (acc && c == C_RESET) begin
        m_mode = M_IDLE; m_core_rst = 1'b1; m_count = 0;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    longint exp_a, exp_b;
    exp_a = (m_count > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_count;
    exp_b = (m_count > 15) ? 15 : m_count;
    check_eq({tag, "_stall"},    {63'd0, stall_a},    {63'd0, !m_active()});
    check_eq({tag, "_ready"},    {63'd0, ready_a},    {63'd0, m_ready()});
    check_eq({tag, "_running"},  {63'd0, running_a},  {63'd0, m_active()});
    check_eq({tag, "_halted"},   {63'd0, halted_a},   {63'd0, m_mode == M_HALTED});
    check_eq({tag, "_done"},     {63'd0, done_a},     {63'd0, m_done});
    check_eq({tag, "_core_rst"}, {63'd0, core_rst_a}, {63'd0, m_core_rst});
    check_eq({tag, "_count"},    {32'd0, cnt_a},      exp_a);
    check_eq({tag, "_s_stall"},  {63'd0, stall_b},    {63'd0, !m_active()});
    check_eq({tag, "_s_ready"},  {63'd0, ready_b},    {63'd0, m_ready()});
    check_eq({tag, "_s_running"},{63'd0, running_b},  {63'd0, m_active()});
    check_eq({tag, "_s_halted"}, {63'd0, halted_b},   {63'd0, m_mode == M_HALTED});
    check_eq({tag, "_s_done"},   {63'd0, done_b},     {63'd0, m_done});
    check_eq({tag, "_s_core_rst"},{63'd0, core_rst_b},{63'd0, m_core_rst});
    check_eq({tag, "_s_count"},  {60'd0, cnt_b},      exp_b);
  endtask

  task automatic tick(input string tag, input bit v, input logic [1:0] c, input logic [31:0] instr);
    i_cmd_valid = v; i_cmd = c; i_instruction = instr;
    model_step(v, c, instr);
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic idle_ticks(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag, 1'b0, C_HALT, 32'h0000_0013);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; i_cmd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    check_outputs("reset");
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset state
    do_reset(3);

    // 2: single step, unstalled for exactly one cycle, done one cycle later
    tick("step_go", 1'b1, C_STEP, 32'h0);
    check_eq("step_stall_low", {63'd0, stall_a}, 64'd0);
    tick("step_end", 1'b0, C_STEP, 32'h0);
    check_eq("step_done", {63'd0, done_a}, 64'd1);
    check_eq("step_count", {32'd0, cnt_a}, 64'd1);
    idle_ticks("step_after", 2);

    // 3: run 10 cycles then host HALT
    tick("clr", 1'b1, C_RESET, 32'h0);
    tick("run_go", 1'b1, C_RUN, 32'h0);
    idle_ticks("run", 9);
    tick("run_halt", 1'b1, C_HALT, 32'h0);
    check_eq("run_count10", {32'd0, cnt_a}, 64'd10);
    check_eq("run_no_done", {63'd0, done_a}, 64'd0);
    idle_ticks("run_idle", 2);

    // 4: auto-halt on HALT_WORD, concurrent HALT command ignored
    tick("ah_go", 1'b1, C_RUN, 32'h0);
    tick("ah_hw", 1'b1, C_HALT, HALT_W);
    idle_ticks("ah_drain", 3);
    check_eq("ah_still_running", {63'd0, running_a}, 64'd1);
    idle_ticks("ah_end", 1);
    check_eq("ah_halted", {63'd0, halted_a}, 64'd1);
    check_eq("ah_done", {63'd0, done_a}, 64'd1);

    // 5: HALTED ignores RUN, RESET_CORE returns to IDLE
    tick("h_run", 1'b1, C_RUN, 32'h0);
    tick("h_step", 1'b1, C_STEP, HALT_W);
    tick("h_rc", 1'b1, C_RESET, 32'h0);
    check_eq("h_core_rst", {63'd0, core_rst_a}, 64'd1);
    check_eq("h_count0", {32'd0, cnt_a}, 64'd0);
    idle_ticks("h_after", 2);

    // 6: saturation on the narrow counter, then reset during drain
    tick("sat_go", 1'b1, C_RUN, 32'h0);
    idle_ticks("sat_run", 19);
    tick("sat_halt", 1'b1, C_HALT, 32'h0);
    check_eq("sat_count15", {60'd0, cnt_b}, 64'd15);
    check_eq("sat_wide20", {32'd0, cnt_a}, 64'd20);
    tick("rd_go", 1'b1, C_RUN, 32'h0);
    tick("rd_hw", 1'b0, C_RUN, HALT_W);
    idle_ticks("rd_drain", 2);
    do_reset(1);
    idle_ticks("rd_after", 6);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1 + $urandom_range(0, 1));
      end else begin
        tick("rnd", ($urandom_range(0, 99) < 40), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 15) == 0) ? HALT_W : $urandom());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
